// File: rtl/uart_ctl_fifo_if.sv
// Host-side byte interface of uart_ctl_fifo: TX request/data, RX FIFO head and status flags.
// The host side uses the master modport, the UART the slave modport.
interface uart_ctl_fifo_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] din;
  logic                 tx_en;
  logic                 tx_rdy;
  logic [DATA_BITS-1:0] dout;
  logic                 d_rdy;
  logic                 rd_en;
  logic                 frm_err;
  logic                 par_err;
  logic                 rx_ovf;

  modport master (
    output din, tx_en, rd_en,
    input  tx_rdy, dout, d_rdy, frm_err, par_err, rx_ovf
  );

  modport slave (
    input  din, tx_en, rd_en,
    output tx_rdy, dout, d_rdy, frm_err, par_err, rx_ovf
  );
endinterface

// File: rtl/uart_ctl_fifo.sv
// Full-duplex UART: shared 16x baud tick, TX FSM, majority-vote RX FSM, show-ahead RX FIFO.
// Define UART_PARITY_EN to add a parity bit (PAR_ODD selects odd parity) on both paths.
module uart_ctl_fifo #(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned BAUD      = 115_200,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned RX_DEPTH  = 4,
  parameter bit          PAR_ODD   = 1'b0
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           rx_i,
  output logic           tx_o,
  uart_ctl_fifo_if.slave host
);

  localparam int unsigned DIV      = CLK_HZ / (16 * BAUD);
  localparam int unsigned DivW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned PtrW     = $clog2(RX_DEPTH);
  localparam logic [4:0]  StopLast = 5'(16 * STOP_BITS - 1);
  localparam logic [2:0]  BitLast  = 3'(DATA_BITS - 1);

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;
  typedef enum logic [2:0] {TxIdle, TxArm, TxStart, TxData, TxParity, TxStop} tx_state_e;
`else
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
  typedef enum logic [2:0] {TxIdle, TxArm, TxStart, TxData, TxStop} tx_state_e;
`endif

  // Baud generator
  logic [DivW-1:0] baud_q, baud_d;
  logic            tick;

  assign tick   = (baud_q == DivW'(DIV - 1));
  assign baud_d = tick ? '0 : baud_q + 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) baud_q <= '0;
    else         baud_q <= baud_d;
  end

  // RX path
  logic [1:0]           sync_q;
  logic                 rx_s;
  rx_state_e            rx_st_q, rx_st_d;
  logic [3:0]           rx_tck_q, rx_tck_d;
  logic [1:0]           rx_vote_q, rx_vote_d;
  logic [2:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
  logic [2:0]           votes;
  logic                 maj;
  logic                 wr_req, frm_err_d, frm_err_q;
`ifdef UART_PARITY_EN
  logic                 rx_par_bad_q, rx_par_bad_d, par_err_d, par_err_q;
`endif

  assign rx_s  = sync_q[1];
  // Samples of ticks 7 and 8 are held; tick 9 is the live sample.
  assign votes = {rx_vote_q, rx_s};
  assign maj   = (votes[0] & votes[1]) | (votes[0] & votes[2]) | (votes[1] & votes[2]);

  always_comb begin
    rx_st_d   = rx_st_q;
    rx_tck_d  = rx_tck_q;
    rx_vote_d = rx_vote_q;
    rx_bit_d  = rx_bit_q;
    rx_sh_d   = rx_sh_q;
    wr_req    = 1'b0;
    frm_err_d = 1'b0;
`ifdef UART_PARITY_EN
    rx_par_bad_d = rx_par_bad_q;
    par_err_d    = 1'b0;
`endif
    if (rx_st_q == RxIdle) begin
      rx_tck_d = '0;
      if (!rx_s) rx_st_d = RxStart;
    end else if (tick) begin
      rx_tck_d = rx_tck_q + 4'd1;
      if (rx_tck_q inside {4'd7, 4'd8}) rx_vote_d = {rx_vote_q[0], rx_s};
      case (rx_st_q)
        RxStart: begin
          if (rx_tck_q == 4'd9 && maj) begin
            rx_st_d = RxIdle;
          end else if (rx_tck_q == 4'd15) begin
            rx_st_d  = RxData;
            rx_bit_d = '0;
          end
        end
        RxData: begin
          if (rx_tck_q == 4'd9) rx_sh_d = {maj, rx_sh_q[DATA_BITS-1:1]};
          if (rx_tck_q == 4'd15) begin
            if (rx_bit_q == BitLast) begin
`ifdef UART_PARITY_EN
              rx_st_d = RxParity;
`else
              rx_st_d = RxStop;
`endif
            end else begin
              rx_bit_d = rx_bit_q + 3'd1;
            end
          end
        end
`ifdef UART_PARITY_EN
        RxParity: begin
          if (rx_tck_q == 4'd9)  rx_par_bad_d = maj ^ (^rx_sh_q) ^ PAR_ODD;
          if (rx_tck_q == 4'd15) rx_st_d = RxStop;
        end
`endif
        RxStop: begin
          if (rx_tck_q == 4'd9) begin
            rx_st_d   = RxIdle;
            frm_err_d = ~maj;
`ifdef UART_PARITY_EN
            par_err_d = rx_par_bad_q;
            wr_req    = maj & ~rx_par_bad_q;
`else
            wr_req    = maj;
`endif
          end
        end
        default: rx_st_d = RxIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q    <= 2'b11;
      rx_st_q   <= RxIdle;
      rx_tck_q  <= '0;
      rx_vote_q <= '0;
      rx_bit_q  <= '0;
      rx_sh_q   <= '0;
      frm_err_q <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_bad_q <= 1'b0;
      par_err_q    <= 1'b0;
`endif
    end else begin
      sync_q    <= {sync_q[0], rx_i};
      rx_st_q   <= rx_st_d;
      rx_tck_q  <= rx_tck_d;
      rx_vote_q <= rx_vote_d;
      rx_bit_q  <= rx_bit_d;
      rx_sh_q   <= rx_sh_d;
      frm_err_q <= frm_err_d;
`ifdef UART_PARITY_EN
      rx_par_bad_q <= rx_par_bad_d;
      par_err_q    <= par_err_d;
`endif
    end
  end

  // RX FIFO
  logic [DATA_BITS-1:0] mem_q [RX_DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]        cnt_q, cnt_d;
  logic                 fifo_empty, fifo_full, rd_ok, wr_ok, rx_ovf_q, rx_ovf_d;

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == (PtrW+1)'(RX_DEPTH));
  assign rd_ok      = host.rd_en & ~fifo_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
  assign wr_ok      = wr_req & (~fifo_full | rd_ok);

  always_comb begin
    cnt_d    = cnt_q;
    rx_ovf_d = rx_ovf_q;
    if (wr_ok && !rd_ok)      cnt_d = cnt_q + 1'b1;
    else if (!wr_ok && rd_ok) cnt_d = cnt_q - 1'b1;
    if (rd_ok)                rx_ovf_d = 1'b0;
    else if (wr_req && !wr_ok) rx_ovf_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[wr_ptr_q] <= rx_sh_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      rx_ovf_q <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q    <= cnt_d;
      rx_ovf_q <= rx_ovf_d;
    end
  end

  assign host.d_rdy   = ~fifo_empty;
  assign host.dout    = fifo_empty ? '0 : mem_q[rd_ptr_q];
  assign host.rx_ovf  = rx_ovf_q;
  assign host.frm_err = frm_err_q;
`ifdef UART_PARITY_EN
  assign host.par_err = par_err_q;
`else
  // PAR_ODD has no effect without the parity bit.
  assign host.par_err = 1'b0 & PAR_ODD;
`endif

  // TX path
  tx_state_e            tx_st_q, tx_st_d;
  logic [4:0]           tx_tck_q, tx_tck_d;
  logic [2:0]           tx_bit_q, tx_bit_d, tx_bit_nx;
  logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
  logic                 tx_q, tx_d;

  always_comb begin
    tx_st_d   = tx_st_q;
    tx_tck_d  = tx_tck_q;
    tx_bit_d  = tx_bit_q;
    tx_data_d = tx_data_q;
    tx_d      = tx_q;
    tx_bit_nx = tx_bit_q + 3'd1;
    case (tx_st_q)
      TxIdle: begin
        if (host.tx_en) begin
          tx_data_d = host.din;
          tx_st_d   = TxArm;
        end
      end
      TxArm: begin
        if (tick) begin
          tx_d     = 1'b0;
          tx_tck_d = '0;
          tx_st_d  = TxStart;
        end
      end
      TxStart: begin
        if (tick) begin
          if (tx_tck_q == 5'd15) begin
            tx_tck_d = '0;
            tx_bit_d = '0;
            tx_d     = tx_data_q[0];
            tx_st_d  = TxData;
          end else begin
            tx_tck_d = tx_tck_q + 5'd1;
          end
        end
      end
      TxData: begin
        if (tick) begin
          if (tx_tck_q == 5'd15) begin
            tx_tck_d = '0;
            if (tx_bit_q == BitLast) begin
`ifdef UART_PARITY_EN
              tx_d    = (^tx_data_q) ^ PAR_ODD;
              tx_st_d = TxParity;
`else
              tx_d    = 1'b1;
              tx_st_d = TxStop;
`endif
            end else begin
              tx_bit_d = tx_bit_nx;
              tx_d     = tx_data_q[tx_bit_nx];
            end
          end else begin
            tx_tck_d = tx_tck_q + 5'd1;
          end
        end
      end
`ifdef UART_PARITY_EN
      TxParity: begin
        if (tick) begin
          if (tx_tck_q == 5'd15) begin
            tx_tck_d = '0;
            tx_d     = 1'b1;
            tx_st_d  = TxStop;
          end else begin
            tx_tck_d = tx_tck_q + 5'd1;
          end
        end
      end
`endif
      TxStop: begin
        if (tick) begin
          if (tx_tck_q == StopLast) tx_st_d = TxIdle;
          else                      tx_tck_d = tx_tck_q + 5'd1;
        end
      end
      default: tx_st_d = TxIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_st_q   <= TxIdle;
      tx_tck_q  <= '0;
      tx_bit_q  <= '0;
      tx_data_q <= '0;
      tx_q      <= 1'b1;
    end else begin
      tx_st_q   <= tx_st_d;
      tx_tck_q  <= tx_tck_d;
      tx_bit_q  <= tx_bit_d;
      tx_data_q <= tx_data_d;
      tx_q      <= tx_d;
    end
  end

  assign tx_o        = tx_q;
  assign host.tx_rdy = (tx_st_q == TxIdle);

endmodule

// File: tb/tb_uart_ctl_fifo.sv
// Directed bench for uart_ctl_fifo at 16 clk per bit (DIV=1); parity steps need UART_PARITY_EN.
`timescale 1ns/1ps
module tb_uart_ctl_fifo;
  localparam int unsigned ClkHz = 1_600_000;
  localparam int unsigned Baud  = 100_000;
`ifdef UART_PARITY_EN
  localparam int FrameBits = 11;
  localparam int RdyClk    = 176;
  localparam logic [10:0] BitsA5 = 11'b10101001010;
  localparam logic [10:0] BitsC3 = 11'b10110000110;
  localparam logic [10:0] Bits3C = 11'b10001111000;
  localparam logic [10:0] Bits07 = 11'b11000001110;
`else
  localparam int FrameBits = 10;
  localparam int RdyClk    = 160;
  localparam logic [10:0] BitsA5 = 11'b01101001010;
  localparam logic [10:0] BitsC3 = 11'b01110000110;
  localparam logic [10:0] Bits3C = 11'b01001111000;
`endif

  logic clk, rst_ni, rx_drv, loop_en, rx_line, tx;
  int   vectors, miscompares, frm_seen, par_seen, f0, p0, k;

  uart_ctl_fifo_if #(.DATA_BITS(8)) dut_if ();

  uart_ctl_fifo #(.CLK_HZ(ClkHz), .BAUD(Baud)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .rx_i   (rx_line),
    .tx_o   (tx),
    .host   (dut_if)
  );

  assign rx_line = loop_en ? tx : rx_drv;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    frm_seen = 0;
    par_seen = 0;
  end
  always @(negedge clk) begin
    if (dut_if.frm_err) frm_seen++;
    if (dut_if.par_err) par_seen++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_rx_frame(input logic [7:0] data, input logic stop_bit, input logic par_flip);
    rx_drv = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = data[i];
      repeat (16) @(negedge clk);
    end
`ifdef UART_PARITY_EN
    rx_drv = (^data) ^ par_flip;
    repeat (16) @(negedge clk);
`else
    rx_drv = 1'b1 | par_flip;
`endif
    rx_drv = stop_bit;
    repeat (16) @(negedge clk);
    rx_drv = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  task automatic pop(input logic [7:0] exp, input string tag);
    check({tag, "_d_rdy"}, dut_if.d_rdy, 1);
    check({tag, "_dout"}, dut_if.dout, exp);
    dut_if.rd_en = 1'b1;
    @(negedge clk);
    dut_if.rd_en = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] data, input string tag);
    int n;
    n = 0;
    while (!dut_if.tx_rdy && n < 400) begin @(negedge clk); n++; end
    check({tag, "_rdy_wait"}, dut_if.tx_rdy, 1);
    dut_if.din   = data;
    dut_if.tx_en = 1'b1;
    @(negedge clk);
    dut_if.tx_en = 1'b0;
  endtask

  // Sends one byte and checks each frame bit mid-bit; abort_at >= 0 pulls reset at that clk.
  task automatic tx_check(input logic [7:0] data, input logic [10:0] bits, input int abort_at,
                          input string tag);
    int n, bidx;
    dut_if.din   = data;
    dut_if.tx_en = 1'b1;
    @(negedge clk);
    dut_if.tx_en = 1'b0;
    n = 0;
    while (tx && n < 40) begin @(negedge clk); n++; end
    check({tag, "_start_seen"}, tx, 0);
    n    = 0;
    bidx = 0;
    while (!dut_if.tx_rdy && n < 400) begin
      if (n == abort_at) begin
        rst_ni = 1'b0;
        #1;
        check({tag, "_async_tx"}, tx, 1);
        check({tag, "_async_rdy"}, dut_if.tx_rdy, 1);
        break;
      end
      if (n % 16 == 8 && bidx < FrameBits) begin
        check($sformatf("%s_bit%0d", tag, bidx), tx, bits[bidx]);
        bidx++;
      end
      if (n == 40) begin
        dut_if.din   = ~data;
        dut_if.tx_en = 1'b1;
      end
      if (n == 41) dut_if.tx_en = 1'b0;
      @(negedge clk);
      n++;
    end
    if (abort_at < 0) begin
      check({tag, "_rdy_low_clk"}, n, RdyClk);
      check({tag, "_bits_checked"}, bidx, FrameBits);
      check({tag, "_idle_tx"}, tx, 1);
    end
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst_ni       = 1'b0;
    rx_drv       = 1'b1;
    loop_en      = 1'b0;
    dut_if.din   = '0;
    dut_if.tx_en = 1'b0;
    dut_if.rd_en = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_tx_rdy", dut_if.tx_rdy, 1);
    check("rst_d_rdy", dut_if.d_rdy, 0);
    check("rst_dout", dut_if.dout, 0);
    check("rst_frm_err", dut_if.frm_err, 0);
    check("rst_par_err", dut_if.par_err, 0);
    check("rst_rx_ovf", dut_if.rx_ovf, 0);
    rst_ni = 1'b1;
    repeat (4) @(negedge clk);

    // TX 0xA5, with a request while busy that must be ignored
    tx_check(8'hA5, BitsA5, -1, "tx_a5");

    // Loopback of three back-to-back bytes
    f0      = frm_seen;
    p0      = par_seen;
    loop_en = 1'b1;
    send_byte(8'h00, "lb0");
    send_byte(8'hFF, "lb1");
    send_byte(8'h5A, "lb2");
    k = 0;
    while (!dut_if.tx_rdy && k < 400) begin @(negedge clk); k++; end
    repeat (24) @(negedge clk);
    loop_en = 1'b0;
    pop(8'h00, "lb_pop0");
    pop(8'hFF, "lb_pop1");
    pop(8'h5A, "lb_pop2");
    check("lb_empty", dut_if.d_rdy, 0);
    check("lb_frm_err", frm_seen - f0, 0);
    check("lb_par_err", par_seen - p0, 0);
    check("lb_rx_ovf", dut_if.rx_ovf, 0);

    // Overflow: five frames, no reads
    for (int i = 1; i <= 5; i++) send_rx_frame(8'(i), 1'b1, 1'b0);
    check("ovf_flag", dut_if.rx_ovf, 1);
    pop(8'h01, "ovf_pop1");
    check("ovf_cleared", dut_if.rx_ovf, 0);
    pop(8'h02, "ovf_pop2");
    pop(8'h03, "ovf_pop3");
    pop(8'h04, "ovf_pop4");
    check("ovf_empty", dut_if.d_rdy, 0);

    // Framing error: stop bit 0
    f0 = frm_seen;
    p0 = par_seen;
    send_rx_frame(8'h3C, 1'b0, 1'b0);
    repeat (16) @(negedge clk);
    check("frm_pulse_cnt", frm_seen - f0, 1);
    check("frm_no_byte", dut_if.d_rdy, 0);
    check("frm_no_par", par_seen - p0, 0);

    // Start-bit glitch of 4 clk
    f0     = frm_seen;
    p0     = par_seen;
    rx_drv = 1'b0;
    repeat (4) @(negedge clk);
    rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_no_byte", dut_if.d_rdy, 0);
    check("glitch_no_frm", frm_seen - f0, 0);
    check("glitch_no_par", par_seen - p0, 0);

`ifdef UART_PARITY_EN
    tx_check(8'h07, Bits07, -1, "tx_07");
    f0 = frm_seen;
    p0 = par_seen;
    send_rx_frame(8'h11, 1'b1, 1'b0);
    send_rx_frame(8'h96, 1'b1, 1'b1);
    check("par_pulse_cnt", par_seen - p0, 1);
    check("par_no_frm", frm_seen - f0, 0);
    pop(8'h11, "par_fifo_head");
    check("par_fifo_empty", dut_if.d_rdy, 0);
`endif

    // Reset during data bit 3, then a clean send
    tx_check(8'h3C, Bits3C, 72, "tx_rst");
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk);
    tx_check(8'hC3, BitsC3, -1, "tx_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
